// File: rtl/mdu_if.sv
// Command/result bundle between the EX stage and the multiply/divide unit.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO,
// holds the architectural HI/LO registers.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);
  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [31:0]   hi, lo, hi_n, lo_n;
  logic [CW-1:0] cnt;
  logic          pend_wr;
  logic          accept;
  logic          div_zero;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   q_s, r_s, q_u, r_u;

  // Accepting on the completion edge (cnt==1) lets a new command follow back-to-back.
  assign accept = bus.start && (cnt <= CNT_ONE) &&
                  (bus.op >= OP_MULT) && (bus.op <= OP_MTLO);

  assign prod_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
  assign prod_u = {32'b0, bus.a} * {32'b0, bus.b};
  assign div_zero = (bus.b == '0);

  always_comb begin
    q_s = '0;
    r_s = '0;
    q_u = '0;
    r_u = '0;
    if (!div_zero) begin
      q_u = bus.a / bus.b;
      r_u = bus.a % bus.b;
      if (bus.a == 32'h8000_0000 && bus.b == '1) begin
        q_s = 32'h8000_0000;
        r_s = '0;
      end else begin
        q_s = $signed(bus.a) / $signed(bus.b);
        r_s = $signed(bus.a) % $signed(bus.b);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= '0;
      lo      <= '0;
      hi_n    <= '0;
      lo_n    <= '0;
      cnt     <= '0;
      pend_wr <= 1'b0;
    end else begin
      if (cnt != '0) begin
        cnt <= cnt - CNT_ONE;
        if (cnt == CNT_ONE && pend_wr) begin
          hi <= hi_n;
          lo <= lo_n;
        end
      end
      // A command accepted on the completion edge overrides the completing write.
      if (accept) begin
        case (bus.op)
          OP_MULT: begin
            hi_n    <= prod_s[63:32];
            lo_n    <= prod_s[31:0];
            pend_wr <= 1'b1;
            cnt     <= MULT_LOAD;
          end
          OP_MULTU: begin
            hi_n    <= prod_u[63:32];
            lo_n    <= prod_u[31:0];
            pend_wr <= 1'b1;
            cnt     <= MULT_LOAD;
          end
          OP_DIV: begin
            hi_n    <= r_s;
            lo_n    <= q_s;
            pend_wr <= !div_zero;
            cnt     <= DIV_LOAD;
          end
          OP_DIVU: begin
            hi_n    <= r_u;
            lo_n    <= q_u;
            pend_wr <= !div_zero;
            cnt     <= DIV_LOAD;
          end
          OP_MTHI: hi <= bus.a;
          OP_MTLO: lo <= bus.a;
          default: ;
        endcase
      end
    end
  end

  assign bus.busy = (cnt != '0);
  assign bus.hi   = hi;
  assign bus.lo   = lo;
endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: a time-based reference model predicts busy/HI/LO per cycle.
module tb_mdu;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  typedef struct {
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
  } exp_t;

  logic clk;
  logic reset;
  mdu_if bus();

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Model: architectural HI/LO, edge count, and the edge at which the pending op completes.
  int unsigned k = 0;
  int unsigned m_done = 0;
  logic        m_pend = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  task automatic model_cmd(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sa, sb, sr, sq, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    ua = {32'b0, x};
    ub = {32'b0, y};
    case (o)
      3'd1: begin sp = sa * sb; p_hi = sp[63:32]; p_lo = sp[31:0]; m_pend = 1'b1; m_done = k + MC; end
      3'd2: begin up = ua * ub; p_hi = up[63:32]; p_lo = up[31:0]; m_pend = 1'b1; m_done = k + MC; end
      3'd3: begin
        m_done = k + DC;
        m_pend = (y != 0);
        if (y != 0) begin sq = sa / sb; sr = sa % sb; p_lo = sq[31:0]; p_hi = sr[31:0]; end
      end
      3'd4: begin
        m_done = k + DC;
        m_pend = (y != 0);
        if (y != 0) begin p_lo = 32'(ua / ub); p_hi = 32'(ua % ub); end
      end
      3'd5: m_hi = x;
      3'd6: m_lo = x;
      default: ;
    endcase
  endtask

  task automatic step(input logic s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    bus.start = s;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    k++;
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_pend = 1'b0; m_done = k;
    end else begin
      if (k == m_done && m_pend) begin
        m_hi = p_hi; m_lo = p_lo; m_pend = 1'b0;
      end
      if (s && k >= m_done) model_cmd(o, x, y);
    end
    e.busy = (k < m_done);
    e.hi   = m_hi;
    e.lo   = m_lo;
    e.cyc  = k;
    q.push_back(e);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 3'd0, '0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        n_cmp++;
        if (bus.busy !== e.busy || bus.hi !== e.hi || bus.lo !== e.lo) begin
          n_bad++;
          $display("FAIL cycle%0d: busy=%b hi=%h lo=%h, expected busy=%b hi=%h lo=%h",
                   e.cyc, bus.busy, bus.hi, bus.lo, e.busy, e.hi, e.lo);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin : stim
    reset = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    idle(3);
    reset = 1'b1;
    idle(1);

    step(1'b1, 3'd1, 32'hFFFF_FFFD, 32'd5); idle(MC + 1);
    step(1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2); idle(MC + 1);
    step(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2); idle(DC + 1);
    step(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF); idle(DC + 1);
    step(1'b1, 3'd5, 32'h1234, '0);
    step(1'b1, 3'd6, 32'h5678, '0);
    step(1'b1, 3'd4, 32'd99, 32'd0); idle(DC + 1);

    // Requests during busy are ignored; commands on the completion edge are accepted.
    step(1'b1, 3'd1, 32'd7, 32'd6);
    step(1'b1, 3'd6, 32'hDEAD, '0);
    step(1'b1, 3'd3, 32'd100, 32'd3);
    idle(MC - 3);
    step(1'b1, 3'd2, 32'h1_0000, 32'h1_0000);
    idle(MC - 1);
    step(1'b1, 3'd5, 32'hBEEF, '0);
    idle(2);

    // Asynchronous reset in the middle of a divide.
    step(1'b1, 3'd5, 32'hAAAA, '0);
    step(1'b1, 3'd3, 32'd50, 32'd7);
    idle(3);
    #5 reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
      n_bad++;
      $display("FAIL async_reset: busy=%b hi=%h lo=%h, expected busy=0 hi=0 lo=0", bus.busy, bus.hi, bus.lo);
    end
    idle(2);
    reset = 1'b1;
    idle(DC + 2);

    for (int unsigned i = 0; i < 500; i++)
      step($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), pick(), pick());
    idle(DC + 2);

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
